// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared JPEG marker constants and bit-packer state encoding
package jpeg_pkg;
  localparam int         JPEG_MAX_CODE_LEN  = 16;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_SOI           = 8'hD8;
  localparam logic [7:0] JPEG_EOI           = 8'hD9;
  typedef enum logic [1:0] {ST_RUN, ST_PAD, ST_DRAIN, ST_DONE} packer_state_t;
endpackage

// File: rtl/jpeg_byte_stuffer.sv
// jpeg_byte_stuffer: output byte register with 0x00 insertion after each 0xFF
module jpeg_byte_stuffer
  import jpeg_pkg::*;
#(
  parameter bit STUFF_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic [7:0] o_byte_data,
  output logic       o_stuff_pend
);
  logic       r_valid, r_pend;
  logic [7:0] r_data;
  logic       w_load;
  assign w_load       = !r_valid | i_byte_ready;
  assign o_ready      = w_load & !r_pend;
  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_data;
  assign o_stuff_pend = r_pend;
  // a pending stuff byte takes the output slot before any new accumulator byte
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_pend  <= 1'b0;
    end else if (w_load) begin
      if (r_pend) begin
        r_data  <= JPEG_STUFF_BYTE;
        r_valid <= 1'b1;
        r_pend  <= 1'b0;
      end else if (i_valid) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
        r_pend  <= STUFF_EN && (i_data == JPEG_MARKER_PREFIX);
      end else begin
        r_valid <= 1'b0;
      end
    end
endmodule

// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: packs right-aligned MSB-first Huffman codes into a stuffed
// JPEG byte stream, padding the final byte with 1s on flush
module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter int MAX_CODE_LEN = JPEG_MAX_CODE_LEN,
  parameter int ACC_W        = 32,
  parameter bit STUFF_EN     = 1'b1
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 i_code_valid,
  output logic                                 o_code_ready,
  input  logic [MAX_CODE_LEN-1:0]              i_code_bits,
  input  logic [$clog2(MAX_CODE_LEN+1)-1:0]    i_code_len,
  input  logic                                 i_flush,
  output logic                                 o_byte_valid,
  input  logic                                 i_byte_ready,
  output logic [7:0]                           o_byte_data,
  output logic                                 o_flush_done,
  output logic                                 o_busy
);
  localparam int FW = $clog2(ACC_W + 1);
  localparam int LW = $clog2(MAX_CODE_LEN + 1);
  logic [ACC_W-1:0] r_acc;
  logic [FW-1:0]    r_fill;
  packer_state_t    r_state, w_state_nx;
  logic [LW-1:0]    w_clen;
  logic [FW-1:0]    w_app_len;
  logic [2:0]       w_pad;
  logic [ACC_W-1:0] w_mask, w_val;
  logic [7:0]       w_byte;
  logic             w_accept, w_have_byte, w_st_ready, w_take, w_stuff_pend, w_drained;
  assign o_code_ready = (r_state == ST_RUN) && (r_fill <= FW'(ACC_W - MAX_CODE_LEN));
  assign w_accept     = i_code_valid & o_code_ready;
  assign w_have_byte  = r_fill >= FW'(8);
  assign w_take       = w_have_byte & w_st_ready;
  // pad count wraps to 0 when already byte aligned
  assign w_pad        = 3'(3'd0 - r_fill[2:0]);
  assign w_byte       = 8'(r_acc >> (r_fill - FW'(8)));
  assign w_drained    = (r_fill == '0) && !w_stuff_pend && (!o_byte_valid || i_byte_ready);
  assign o_flush_done = r_state == ST_DONE;
  assign o_busy       = (r_fill != '0) | o_byte_valid | w_stuff_pend | (r_state != ST_RUN);
  always_comb begin
    w_clen    = (i_code_len > LW'(MAX_CODE_LEN)) ? LW'(MAX_CODE_LEN) : i_code_len;
    w_app_len = w_accept ? FW'(w_clen) : (r_state == ST_PAD) ? FW'(w_pad) : '0;
    w_mask    = (ACC_W'(1) << w_app_len) - ACC_W'(1);
    w_val     = w_accept ? (ACC_W'(i_code_bits) & w_mask) : w_mask;
  end
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == ST_RUN)   ? (i_flush ? ST_PAD : ST_RUN) :
                 (r_state == ST_PAD)   ? ST_DRAIN :
                 (r_state == ST_DRAIN) ? (w_drained ? ST_DONE : ST_DRAIN) : ST_RUN;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_acc   <= '0;
      r_fill  <= '0;
      r_state <= ST_RUN;
    end else begin
      r_acc   <= (r_acc << w_app_len) | w_val;
      r_fill  <= r_fill + w_app_len - (w_take ? FW'(8) : FW'(0));
      r_state <= w_state_nx;
    end
  jpeg_byte_stuffer #(.STUFF_EN(STUFF_EN)) u_stuffer (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_valid      (w_have_byte),
    .i_data       (w_byte),
    .o_ready      (w_st_ready),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_byte_data  (o_byte_data),
    .o_stuff_pend (w_stuff_pend)
  );
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer: directed scoreboard bench for jpeg_bit_packer
module tb_jpeg_bit_packer;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        i_code_valid = 1'b0, i_flush = 1'b0, i_byte_ready = 1'b1;
  logic [15:0] i_code_bits = '0;
  logic [4:0]  i_code_len = '0;
  logic        o_code_ready, o_byte_valid, o_flush_done, o_busy;
  logic [7:0]  o_byte_data;
  logic        ns_code_valid = 1'b0, ns_code_ready, ns_byte_valid, ns_flush_done, ns_busy;
  logic [7:0]  ns_byte_data;
  int          tests = 0, fails = 0;
  logic [7:0]  exp_q[$], ns_got[$];
  longint unsigned m_acc = 0;
  int          m_fill = 0;

  always #5 clock = ~clock;

  jpeg_bit_packer u_dut (
    .clock(clock), .reset_n(reset_n), .i_code_valid(i_code_valid), .o_code_ready(o_code_ready),
    .i_code_bits(i_code_bits), .i_code_len(i_code_len), .i_flush(i_flush),
    .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready), .o_byte_data(o_byte_data),
    .o_flush_done(o_flush_done), .o_busy(o_busy));

  jpeg_bit_packer #(.STUFF_EN(1'b0)) u_dut_ns (
    .clock(clock), .reset_n(reset_n), .i_code_valid(ns_code_valid), .o_code_ready(ns_code_ready),
    .i_code_bits(i_code_bits), .i_code_len(i_code_len), .i_flush(1'b0),
    .o_byte_valid(ns_byte_valid), .i_byte_ready(1'b1), .o_byte_data(ns_byte_data),
    .o_flush_done(ns_flush_done), .o_busy(ns_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_emit();
    logic [7:0] b;
    while (m_fill >= 8) begin
      b = 8'(m_acc >> (m_fill - 8));
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
      m_fill -= 8;
    end
  endtask

  task automatic model_code(input logic [15:0] b, input logic [4:0] l);
    int n = (l > 16) ? 16 : int'(l);
    m_acc  = (m_acc << n) | (64'(b) & ((64'd1 << n) - 1));
    m_fill += n;
    model_emit();
  endtask

  task automatic model_pad();
    int p;
    if (m_fill % 8 != 0) begin
      p = 8 - m_fill % 8;
      m_acc  = (m_acc << p) | ((64'd1 << p) - 1);
      m_fill += p;
    end
    model_emit();
  endtask

  // scoreboard: every visible byte must match the head of the expected queue
  always @(negedge clock)
    if (reset_n) begin
      if (o_byte_valid) begin
        check("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("byte_data", o_byte_data, exp_q[0]);
          if (i_byte_ready) void'(exp_q.pop_front());
        end
      end
      if (ns_byte_valid) ns_got.push_back(ns_byte_data);
    end

  task automatic send(input logic [15:0] b, input logic [4:0] l);
    bit done = 0;
    i_code_valid = 1'b1; i_code_bits = b; i_code_len = l;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      if (o_code_ready) begin
        done = 1;
        model_code(b, l);
      end
      @(posedge clock); #1;
    end
    i_code_valid = 1'b0;
    check("send_accepted", 32'(done), 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int t = 1; t <= 300 && n == 0; t++) begin
      @(negedge clock);
      if (o_flush_done) n = t;
    end
    check("flush_done_seen", 32'(n != 0), 1);
  endtask

  task automatic do_flush(output int n);
    model_pad();
    i_flush = 1'b1;
    @(posedge clock); #1;
    i_flush = 1'b0;
    wait_done(n);
  endtask

  task automatic after_done(input string tag);
    @(negedge clock);
    check({tag, "_pulse1"}, o_flush_done, 0);
    check({tag, "_idle"}, o_busy, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 0;
    for (int t = 0; t < 500 && !idle; t++) begin
      @(negedge clock);
      idle = (exp_q.size() == 0) && !o_busy;
    end
    check({tag, "_idle"}, 32'(idle), 1);
    @(posedge clock); #1;
  endtask

  initial begin
    int n, acc_cnt;
    bit drop;
    repeat (2) @(posedge clock);
    #1;
    check("rst_byte_valid", o_byte_valid, 0);
    check("rst_byte_data", o_byte_data, 0);
    check("rst_flush_done", o_flush_done, 0);
    check("rst_code_ready", o_code_ready, 1);
    check("rst_busy", o_busy, 0);
    reset_n = 1'b1;

    // 1: 101 + 11111 -> 0xBF, valid two cycles after second accept
    send(16'b101, 5'd3);
    i_code_valid = 1'b1; i_code_bits = 16'h001F; i_code_len = 5'd5;
    @(negedge clock);
    check("t1_ready", o_code_ready, 1);
    model_code(16'h001F, 5'd5);
    @(posedge clock); #1;
    i_code_valid = 1'b0;
    @(negedge clock);
    check("t1_lat_n1", o_byte_valid, 0);
    @(negedge clock);
    check("t1_lat_n2", o_byte_valid, 1);
    check("t1_byte", o_byte_data, 8'hBF);
    @(posedge clock); #1;
    wait_idle("t1");

    // 2: 0xFF stuffed; the no-stuff instance emits 0xFF alone
    i_code_valid = 1'b1; ns_code_valid = 1'b1; i_code_bits = 16'h00FF; i_code_len = 5'd8;
    @(negedge clock);
    check("t2_ready", o_code_ready & ns_code_ready, 1);
    model_code(16'h00FF, 5'd8);
    @(posedge clock); #1;
    i_code_valid = 1'b0; ns_code_valid = 1'b0;
    wait_idle("t2");
    repeat (3) @(posedge clock);
    #1;
    check("t2_ns_count", ns_got.size(), 1);
    check("t2_ns_byte", (ns_got.size() != 0) ? ns_got[0] : 8'h00, 8'hFF);

    // 3: 010 then flush -> 0x5F
    send(16'b010, 5'd3);
    do_flush(n);
    after_done("t3");

    // 4: code and flush together on an empty packer -> FF 00
    i_code_valid = 1'b1; i_code_bits = 16'h0003; i_code_len = 5'd2; i_flush = 1'b1;
    @(negedge clock);
    check("t4_ready", o_code_ready, 1);
    model_code(16'h0003, 5'd2);
    model_pad();
    @(posedge clock); #1;
    i_code_valid = 1'b0; i_flush = 1'b0;
    wait_done(n);
    after_done("t4");

    // empty flush completes three cycles later
    do_flush(n);
    check("empty_flush_lat", n, 3);
    after_done("tempty");

    // 5: masking, zero-length no-op, over-length clamp
    send(16'hFFFF, 5'd4);
    send(16'h0000, 5'd0);
    send(16'h0000, 5'd4);
    send(16'h00A5, 5'd20);
    wait_idle("t5");

    // 6: backpressure while streaming 0xABCD
    i_byte_ready = 1'b0; acc_cnt = 0; drop = 0;
    for (int c = 0; c < 20; c++) begin
      i_code_valid = 1'b1; i_code_bits = 16'hABCD; i_code_len = 5'd16;
      @(negedge clock);
      if (o_code_ready) begin
        acc_cnt++;
        model_code(16'hABCD, 5'd16);
      end else drop = 1;
      @(posedge clock); #1;
    end
    i_code_valid = 1'b0;
    check("t6_ready_dropped", 32'(drop), 1);
    check("t6_accepts", acc_cnt, 2);
    i_byte_ready = 1'b1;
    wait_idle("t6");

    // 7: reset while stalled in drain
    i_byte_ready = 1'b0;
    send(16'h0012, 5'd8);
    send(16'h0034, 5'd8);
    i_flush = 1'b1;
    @(posedge clock); #1;
    i_flush = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("t7_stalled_busy", o_busy, 1);
    reset_n = 1'b0;
    #1;
    check("t7_rst_valid", o_byte_valid, 0);
    check("t7_rst_ready", o_code_ready, 1);
    exp_q.delete();
    m_acc = 0; m_fill = 0;
    i_byte_ready = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    send(16'h005A, 5'd8);
    wait_idle("t7");
    repeat (10) @(posedge clock);
    #1;
    check("t7_no_extra", exp_q.size(), 0);
    check("t7_final_idle", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end
endmodule
